parking_gate_controller: RTL and testbench
==========================================

// Module: parking_gate_controller
// PURPOSE
//  Sequences the single barrier gate of the car park and shares it between entry and exit requests.
//  Inputs are 1-cycle pulses from the push-button/sensor debouncers. Block owns occupancy count.
//  Grants one request at a time, holds gate open for a timed window, and keeps it open while a car blocks it.
//  Sits between the debouncer outputs and the gate actuator / display logic.
// PARAMETERS
//  CAPACITY     8           max cars; entry refused when occupancy == CAPACITY (>=1)
//  OPEN_CYCLES  200_000_000 clk cycles gate stays open after grant (5 s @ 40 MHz, >=2)
//  CNT_W        $clog2(CAPACITY+1) occupancy width (localparam, derived)
//  TMR_W        $clog2(OPEN_CYCLES) timer width (localparam, derived)
// PORTS
//  clk            in   1      system clock, all logic rising-edge
//  reset          in   1      asynchronous, active-high reset
//  entry_req      in   1      1-cycle debounced pulse, car wants in
//  exit_req       in   1      1-cycle debounced pulse, car wants out
//  car_present    in   1      level, high while vehicle under the barrier
//  gate_open      out  1      registered, high = drive barrier open
//  entry_grant    out  1      registered 1-cycle pulse, entry accepted
//  exit_grant     out  1      registered 1-cycle pulse, exit accepted
//  entry_denied   out  1      registered 1-cycle pulse, entry refused (full)
//  occupancy      out  CNT_W  registered car count
//  full           out  1      occupancy == CAPACITY (combinational from occupancy register)
//  busy           out  1      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, gate_open=0, all pulses 0, occupancy=0, timer=0, pending flags=0. Same on reset mid-operation.
//  Pending flags: entry_pend/exit_pend set on the req pulse in any state; repeated pulses while set are merged (no queue depth >1).
//  Flag clears on the cycle it is granted or refused. A req pulse in the same cycle as its flag clears re-sets it.
//  FSM states: IDLE, OPEN, HOLD, CLOSE.
//  IDLE arbitration (uses flag OR same-cycle pulse):
//   - exit pending and occupancy>0 -> exit wins (frees space). Next cycle: state=OPEN, gate_open=1, exit_grant=1, occupancy-1.
//   - else entry pending and !full -> same, with entry_grant and occupancy+1.
//   - entry pending and full -> entry_denied=1 next cycle, flag cleared, stay IDLE.
//   - exit pending and occupancy==0 -> flag dropped silently, stay IDLE.
//   - A deferred entry stays pending after an exit grant.
//  OPEN: timer counts 0..OPEN_CYCLES-1 from the cycle after grant. At terminal count: car_present ? HOLD : CLOSE.
//   gate_open is high exactly OPEN_CYCLES cycles minimum.
//  HOLD: gate_open=1 until car_present samples 0, then CLOSE.
//  CLOSE: gate_open=0 for exactly 1 cycle, then IDLE. This guarantees >=1 low cycle between consecutive grants.
//  Grant-to-grant minimum spacing = OPEN_CYCLES+2 cycles.
//  Occupancy saturates: never wraps below 0 or above CAPACITY, by construction of the arbitration.
//  No combinational path from inputs to outputs except full (from register).
// TESTING (CAPACITY=2, OPEN_CYCLES=4)
//  1 entry_req pulse at T, car_present=0 -> entry_grant at T+1, gate_open T+1..T+4, low T+5, occupancy=1, busy low T+6.
//  2 entry then car_present held high until T+9 -> gate_open stays high through T+9, low at T+10, IDLE at T+11.
//  3 occupancy=2, entry_req -> entry_denied 1-cycle pulse, gate_open stays 0, occupancy stays 2.
//  4 occupancy=1, entry_req and exit_req same cycle -> exit_grant first (occupancy 0).
//    Then entry_grant exactly OPEN_CYCLES+2 cycles later (occupancy 1).
//  5 exit_req with occupancy=0 -> no grant, no gate; three entry_req pulses during OPEN -> exactly one extra grant.
//  6 assert reset during HOLD -> gate_open, occupancy, pending flags and pulses all 0 immediately (async).
//    FSM is IDLE after release.

Source files
------------

// File: rtl/parking_gate_controller.sv
// Single-barrier car park gate sequencer: arbitrates entry/exit requests,
// owns the occupancy count and times the open window of the barrier.
module parking_gate_controller #(
  parameter int CAPACITY    = 8,
  parameter int OPEN_CYCLES = 200_000_000,
  localparam int CNT_W      = $clog2(CAPACITY + 1),
  localparam int TMR_W      = $clog2(OPEN_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             car_present,
  output logic             gate_open,
  output logic             entry_grant,
  output logic             exit_grant,
  output logic             entry_denied,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, OPEN, HOLD, CLOSE} state_t;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(CAPACITY);

  state_t             state, state_n;
  logic [TMR_W-1:0]   timer, timer_n;
  logic [CNT_W-1:0]   occ_n;
  logic               gate_n, entry_grant_n, exit_grant_n, entry_denied_n;
  logic               entry_pend, exit_pend, entry_pend_n, exit_pend_n;
  logic               entry_clr, exit_clr, entry_eff, exit_eff;

  assign full      = (occupancy == CNT_CAP);
  assign busy      = (state != IDLE);
  assign entry_eff = entry_pend | entry_req;
  assign exit_eff  = exit_pend | exit_req;

  always_comb begin
    state_n        = state;
    timer_n        = timer;
    occ_n          = occupancy;
    entry_grant_n  = 1'b0;
    exit_grant_n   = 1'b0;
    entry_denied_n = 1'b0;
    entry_clr      = 1'b0;
    exit_clr       = 1'b0;
    case (state)
      IDLE: begin
        // Exit takes priority because it frees a space; a deferred entry stays pending.
        if (exit_eff && (occupancy != '0)) begin
          state_n      = OPEN;
          timer_n      = '0;
          exit_grant_n = 1'b1;
          occ_n        = occupancy - CNT_W'(1);
          exit_clr     = 1'b1;
        end else begin
          if (exit_eff) exit_clr = 1'b1;
          if (entry_eff && !full) begin
            state_n       = OPEN;
            timer_n       = '0;
            entry_grant_n = 1'b1;
            occ_n         = occupancy + CNT_W'(1);
            entry_clr     = 1'b1;
          end else if (entry_eff) begin
            entry_denied_n = 1'b1;
            entry_clr      = 1'b1;
          end
        end
      end
      OPEN: begin
        if (timer == TMR_LAST) state_n = car_present ? HOLD : CLOSE;
        else                   timer_n = timer + TMR_W'(1);
      end
      HOLD: begin
        if (!car_present) state_n = CLOSE;
      end
      CLOSE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase

    gate_n = (state_n == OPEN) || (state_n == HOLD);

    // A pulse arriving as an already-set flag is consumed keeps the flag set;
    // a pulse consumed directly in the same cycle does not.
    entry_pend_n = entry_clr ? (entry_pend & entry_req) : (entry_pend | entry_req);
    exit_pend_n  = exit_clr  ? (exit_pend  & exit_req)  : (exit_pend  | exit_req);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      gate_open    <= 1'b0;
      entry_grant  <= 1'b0;
      exit_grant   <= 1'b0;
      entry_denied <= 1'b0;
      occupancy    <= '0;
      entry_pend   <= 1'b0;
      exit_pend    <= 1'b0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      gate_open    <= gate_n;
      entry_grant  <= entry_grant_n;
      exit_grant   <= exit_grant_n;
      entry_denied <= entry_denied_n;
      occupancy    <= occ_n;
      entry_pend   <= entry_pend_n;
      exit_pend    <= exit_pend_n;
    end
  end

endmodule

// File: tb/tb_parking_gate_controller.sv
// Bench for parking_gate_controller: vector table, directed corner sequences
// and random traffic against a timeline-style reference model.
module tb_parking_gate_controller;

  localparam int CAP = 2;
  localparam int OPN = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       entry_req, exit_req, car_present;
  logic       gate_open, entry_grant, exit_grant, entry_denied, full, busy;
  logic [1:0] occupancy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  parking_gate_controller #(.CAPACITY(CAP), .OPEN_CYCLES(OPN)) dut (
    .clk(clk), .reset(reset), .entry_req(entry_req), .exit_req(exit_req),
    .car_present(car_present), .gate_open(gate_open), .entry_grant(entry_grant),
    .exit_grant(exit_grant), .entry_denied(entry_denied), .occupancy(occupancy),
    .full(full), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: cars counted, requests remembered as booleans, and the
  // gate described by how many open cycles remain, whether a car holds it,
  // and whether the one mandatory closed cycle is in progress.
  int m_occ, m_open_left;
  bit m_ep, m_xp, m_hold, m_closing, m_eg, m_xg, m_ed;

  function automatic void model_reset();
    m_occ = 0; m_open_left = 0; m_ep = 0; m_xp = 0;
    m_hold = 0; m_closing = 0; m_eg = 0; m_xg = 0; m_ed = 0;
  endfunction

  function automatic void model_step(bit er, bit xr, bit cp);
    bit eclr = 0, xclr = 0;
    bit e_eff = m_ep | er;
    bit x_eff = m_xp | xr;
    m_eg = 0; m_xg = 0; m_ed = 0;
    if (m_open_left > 1) m_open_left--;
    else if (m_open_left == 1) begin
      m_open_left = 0;
      if (cp) m_hold = 1; else m_closing = 1;
    end else if (m_hold) begin
      if (!cp) begin m_hold = 0; m_closing = 1; end
    end else if (m_closing) m_closing = 0;
    else begin
      if (x_eff && m_occ > 0) begin
        m_xg = 1; m_occ--; m_open_left = OPN; xclr = 1;
      end else begin
        if (x_eff) xclr = 1;
        if (e_eff && m_occ < CAP) begin
          m_eg = 1; m_occ++; m_open_left = OPN; eclr = 1;
        end else if (e_eff) begin
          m_ed = 1; eclr = 1;
        end
      end
    end
    m_ep = eclr ? (m_ep & er) : (m_ep | er);
    m_xp = xclr ? (m_xp & xr) : (m_xp | xr);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic compare_model();
    chk("gate_open",    int'(gate_open),    int'((m_open_left > 0) || m_hold));
    chk("entry_grant",  int'(entry_grant),  int'(m_eg));
    chk("exit_grant",   int'(exit_grant),   int'(m_xg));
    chk("entry_denied", int'(entry_denied), int'(m_ed));
    chk("occupancy",    int'(occupancy),    m_occ);
    chk("full",         int'(full),         int'(m_occ == CAP));
    chk("busy",         int'(busy),         int'((m_open_left > 0) || m_hold || m_closing));
  endtask

  // Drive one cycle of inputs, let the edge happen, then check on the falling edge.
  task automatic step(input bit er, input bit xr, input bit cp);
    entry_req = er; exit_req = xr; car_present = cp;
    @(posedge clk);
    model_step(er, xr, cp);
    @(negedge clk);
    cyc++;
    compare_model();
  endtask

  typedef struct {
    bit er, xr, cp;
    bit gate, eg, xg, ed, bsy;
    int occ;
  } vec_t;
  vec_t tv[6];

  int k_grant, grants;

  initial begin
    // Single entry, no car: grant next cycle, four open cycles, one closed, idle.
    tv[0] = '{1,0,0, 1,1,0,0,1, 1};
    tv[1] = '{0,0,0, 1,0,0,0,1, 1};
    tv[2] = '{0,0,0, 1,0,0,0,1, 1};
    tv[3] = '{0,0,0, 1,0,0,0,1, 1};
    tv[4] = '{0,0,0, 0,0,0,0,1, 1};
    tv[5] = '{0,0,0, 0,0,0,0,0, 1};

    reset = 1'b1; entry_req = 0; exit_req = 0; car_present = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_model();
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      step(tv[i].er, tv[i].xr, tv[i].cp);
      chk($sformatf("tv%0d_gate", i), int'(gate_open),    int'(tv[i].gate));
      chk($sformatf("tv%0d_eg", i),   int'(entry_grant),  int'(tv[i].eg));
      chk($sformatf("tv%0d_xg", i),   int'(exit_grant),   int'(tv[i].xg));
      chk($sformatf("tv%0d_ed", i),   int'(entry_denied), int'(tv[i].ed));
      chk($sformatf("tv%0d_busy", i), int'(busy),         int'(tv[i].bsy));
      chk($sformatf("tv%0d_occ", i),  int'(occupancy),    tv[i].occ);
    end

    // Car under barrier through T+8, gone at T+9.
    step(1, 0, 0);
    for (int k = 2; k <= 9; k++) step(0, 0, 1);
    chk("hold_gate_T9", int'(gate_open), 1);
    step(0, 0, 0);
    chk("hold_gate_T10", int'(gate_open), 0);
    step(0, 0, 0);
    chk("hold_busy_T11", int'(busy), 0);
    chk("hold_occ", int'(occupancy), 2);

    // Full: entry refused with a single pulse, gate untouched.
    step(1, 0, 0);
    chk("deny_pulse", int'(entry_denied), 1);
    chk("deny_gate", int'(gate_open), 0);
    step(0, 0, 0);
    chk("deny_once", int'(entry_denied), 0);
    chk("deny_occ", int'(occupancy), 2);

    step(0, 1, 0);
    repeat (6) step(0, 0, 0);

    // Simultaneous entry and exit at occupancy 1.
    step(1, 1, 0);
    chk("both_exit_first", int'(exit_grant), 1);
    chk("both_occ0", int'(occupancy), 0);
    k_grant = -1;
    for (int k = 2; k <= 20; k++) begin
      step(0, 0, 0);
      if (entry_grant) begin k_grant = k; break; end
    end
    chk("both_entry_spacing", k_grant, OPN + 3);
    chk("both_occ1", int'(occupancy), 1);
    repeat (6) step(0, 0, 0);

    step(0, 1, 0);
    repeat (6) step(0, 0, 0);
    // Exit on an empty park is ignored.
    step(0, 1, 0);
    chk("empty_exit_grant", int'(exit_grant), 0);
    chk("empty_exit_gate", int'(gate_open), 0);
    step(0, 0, 0);
    chk("empty_exit_busy", int'(busy), 0);
    // Three entry pulses during OPEN merge into one extra grant.
    step(1, 0, 0);
    grants = 0;
    step(1, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    for (int k = 0; k < 16; k++) begin
      step(0, 0, 0);
      if (entry_grant) grants++;
    end
    chk("merged_grants", grants, 1);
    chk("merged_occ", int'(occupancy), 2);

    // Asynchronous reset while a car holds the gate, with an entry pending.
    step(0, 1, 1);
    repeat (6) step(0, 0, 1);
    step(1, 0, 1);
    chk("pre_reset_hold", int'(gate_open), 1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("rst_gate", int'(gate_open), 0);
    chk("rst_occ", int'(occupancy), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pulses", int'({entry_grant, exit_grant, entry_denied}), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) step(0, 0, 0);
    chk("post_rst_no_grant", int'(gate_open), 0);

    // Random traffic.
    for (int k = 0; k < 600; k++)
      step($urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 3) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
